normalize_seq: RTL
==================

Name: normalize_seq

Overview:
- Multi-cycle, parametrised post-add normaliser for the FP adder datapath. Sits between the significand ALU and the rounding module.
- Takes the raw summed significand, the ALU carry-out and the pre-normalisation exponent. Returns a normalised or denormal significand, the final exponent, and status flags.
- Left normalisation is iterative: at most SHIFT_STEP positions per cycle, so no full-width barrel shifter is needed.
- Valid/ready handshakes are used on both the input and the output side.

Parameters:
- SIG_W, 24, significand width including the hidden bit (MSB = hidden-bit position).
- EXP_W, 8, biased exponent width.
- SHIFT_STEP, 4, maximum left-shift positions per cycle; legal range 1..SIG_W-1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept an operand.
- sig  in  SIG_W  summed significand from the ALU.
- carryout  in  1  ALU carry-out.
- exp  in  EXP_W  exponent before normalisation.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sig_norm  out  SIG_W  normalised (or denormal) significand.
- exp_norm  out  EXP_W  final biased exponent.
- lshift  out  $clog2(SIG_W+1)  total left-shift positions applied.
- sticky  out  1  bit shifted out on a right shift (carry case), else 0.
- zero  out  1  result is zero.
- denorm  out  1  result is denormal (exp_norm = 0, sig_norm nonzero).
- overflow  out  1  exponent overflowed; result is infinity.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - All data outputs and flags = 0.
  - Any in-flight operation is discarded. On release, the block is idle the next cycle.
- States: IDLE, SHIFT, DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
  - There is no overlap between operations.
- Accept: in_valid && in_ready at a rising edge. On accept, the operands are registered and classified. Classification is by priority, first match wins:
  1. carryout = 1:
     - sig_r = {1'b1, sig[SIG_W-1:1]}, sticky = sig[0], exp_r = exp+1, lshift = 0.
     - If exp+1 = all ones: overflow = 1, sig_r = 0.
     - Next state DONE.
  2. sig = 0:
     - sig_r = 0, exp_r = 0, zero = 1.
     - Next state DONE.
  3. exp = 0:
     - Already denormal: no shift, denorm = 1.
     - Next state DONE.
  4. sig[SIG_W-1] = 1:
     - Already normal; pass through.
     - Next state DONE.
  5. exp = 1 and sig[SIG_W-1] = 0:
     - exp_r = 0, denorm = 1, no shift.
     - Next state DONE.
  6. Otherwise: next state SHIFT.
- SHIFT, one step per cycle:
  - lz = leading zeros of sig_r.
  - k = min(lz, SHIFT_STEP, exp_r-1).
  - sig_r <<= k, exp_r -= k, lshift += k.
  - Exit to DONE when either:
    - the shifted value's MSB = 1; or
    - the new exp_r = 1 with MSB still 0. In that case set exp_r = 0 and denorm = 1 in the same step.
  - Otherwise stay in SHIFT.
- Latency (accept edge to first cycle out_valid = 1):
  - Cases 1-5: 1 cycle.
  - Case 6: 1 + N cycles, with N = ceil(min(lz0, exp-1) / SHIFT_STEP).
- DONE:
  - Outputs are registered and held stable while out_ready = 0.
  - On out_valid && out_ready: go to IDLE. The next accept is possible on the following edge.
  - out_valid drops in IDLE. Data outputs keep their last values (don't-care to consumers).
- Flags are mutually exclusive except that sticky may accompany overflow.
- Arithmetic: exp_r is EXP_W bits. Rule 1 never wraps (overflow catches all ones). SHIFT never decrements exp_r below 1 before the denormal conversion.
- in_valid while busy: ignored; the source must hold it per valid/ready.

Test Plan (SIG_W=24, EXP_W=8, SHIFT_STEP=4):
1. carryout=1, sig=24'h800001, exp=10 -> sig_norm=24'hC00000, exp_norm=11, sticky=1, lshift=0, out_valid 1 cycle after accept.
2. carryout=0, sig=24'h000010, exp=100 -> sig_norm=24'h800000, exp_norm=81, lshift=19, out_valid 6 cycles after accept.
3. sig=24'h000100, exp=5 -> one step of 4, sig_norm=24'h001000, exp_norm=0, denorm=1, lshift=4, latency 2.
4. sig=0, exp=1 -> zero=1, exp_norm=0, sig_norm=0, latency 1. Separately: carryout=1, exp=8'hFE -> exp_norm=8'hFF, overflow=1, sig_norm=0.
5. Backpressure: result of case 2 with out_ready=0 for 3 cycles -> outputs stable, in_ready=0, new in_valid not accepted. out_ready=1 -> IDLE next cycle.
6. Reset mid-operation: rst_n low during SHIFT of case 2 -> out_valid=0, in_ready=1 immediately. After release, a fresh case-1 operand produces the correct result.

Source files
------------

// File: rtl/normalize_seq_if.sv
// Handshake bundle for the post-add normaliser: operand side (ALU) and result side (rounder).
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports: in_valid/in_ready/sig/carryout/exp from the ALU; out_valid/out_ready/sig_norm/exp_norm/
//        lshift/sticky/zero/denorm/overflow toward the rounder.
interface normalize_seq_if #(
    parameter int SIG_W = 24,
    parameter int EXP_W = 8
) ();
    localparam int LS_W = $clog2(SIG_W + 1);

    logic             in_valid;
    logic             in_ready;
    logic [SIG_W-1:0] sig;
    logic             carryout;
    logic [EXP_W-1:0] exp;

    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] sig_norm;
    logic [EXP_W-1:0] exp_norm;
    logic [LS_W-1:0]  lshift;
    logic             sticky;
    logic             zero;
    logic             denorm;
    logic             overflow;

    // Driven by the ALU / consumed by the rounder.
    modport master (
        output in_valid, sig, carryout, exp, out_ready,
        input  in_ready, out_valid, sig_norm, exp_norm, lshift, sticky, zero, denorm, overflow
    );

    // The normaliser itself.
    modport slave (
        input  in_valid, sig, carryout, exp, out_ready,
        output in_ready, out_valid, sig_norm, exp_norm, lshift, sticky, zero, denorm, overflow
    );
endinterface

// File: rtl/normalize_seq.sv
// Post-add normaliser: classifies the summed significand, then left-normalises SHIFT_STEP bits/cycle.
// Latency: 1 cycle for carry/zero/denormal/normal/exp==1 cases, 1+ceil(min(lz,exp-1)/SHIFT_STEP) otherwise.
// Backpressure: one operation in flight; in_ready only when idle, result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), bus (normalize_seq_if.slave: operand and result handshakes).
module normalize_seq #(
    parameter int SIG_W      = 24,
    parameter int EXP_W      = 8,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    normalize_seq_if.slave  bus
);
    localparam int LS_W = $clog2(SIG_W + 1);
    // Common width for comparing shift counts against the exponent without truncation.
    localparam int CW   = ((EXP_W > LS_W) ? EXP_W : LS_W) + 1;
    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [SIG_W-1:0] r_sig;
    logic [EXP_W-1:0] r_exp;
    logic [LS_W-1:0]  r_lshift;
    logic             r_sticky;
    logic             r_zero;
    logic             r_denorm;
    logic             r_overflow;

    state_t           w_state_nxt;
    logic [SIG_W-1:0] w_sig_nxt;
    logic [EXP_W-1:0] w_exp_nxt;
    logic [LS_W-1:0]  w_lshift_nxt;
    logic             w_sticky_nxt;
    logic             w_zero_nxt;
    logic             w_denorm_nxt;
    logic             w_overflow_nxt;

    logic [LS_W-1:0]  w_lz;
    logic [CW-1:0]    w_expm1;
    logic [CW-1:0]    w_k_ext;
    logic [LS_W-1:0]  w_k;
    logic [SIG_W-1:0] w_sig_sh;
    logic [EXP_W-1:0] w_exp_sh;

    // Leading-zero count of the working significand; ascending scan so the highest set bit wins.
    always_comb begin
        w_lz = LS_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (r_sig[i]) begin
                w_lz = LS_W'(SIG_W - 1 - i);
            end
        end
    end

    // Step size: never more than the zeros available, the per-cycle limit, or what keeps exp >= 1.
    assign w_expm1 = CW'(r_exp) - CW'(1);

    always_comb begin
        w_k_ext = CW'(w_lz);
        if (w_k_ext > CW'(SHIFT_STEP)) begin
            w_k_ext = CW'(SHIFT_STEP);
        end
        if (w_k_ext > w_expm1) begin
            w_k_ext = w_expm1;
        end
    end

    assign w_k      = LS_W'(w_k_ext);
    assign w_sig_sh = r_sig << w_k;
    assign w_exp_sh = r_exp - EXP_W'(w_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sig      <= '0;
            r_exp      <= '0;
            r_lshift   <= '0;
            r_sticky   <= 1'b0;
            r_zero     <= 1'b0;
            r_denorm   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sig      <= w_sig_nxt;
            r_exp      <= w_exp_nxt;
            r_lshift   <= w_lshift_nxt;
            r_sticky   <= w_sticky_nxt;
            r_zero     <= w_zero_nxt;
            r_denorm   <= w_denorm_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sig_nxt      = r_sig;
        w_exp_nxt      = r_exp;
        w_lshift_nxt   = r_lshift;
        w_sticky_nxt   = r_sticky;
        w_zero_nxt     = r_zero;
        w_denorm_nxt   = r_denorm;
        w_overflow_nxt = r_overflow;

        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_sig_nxt      = bus.sig;
                    w_exp_nxt      = bus.exp;
                    w_lshift_nxt   = '0;
                    w_sticky_nxt   = 1'b0;
                    w_zero_nxt     = 1'b0;
                    w_denorm_nxt   = 1'b0;
                    w_overflow_nxt = 1'b0;
                    w_state_nxt    = S_DONE;
                    if (bus.carryout) begin
                        w_sticky_nxt = bus.sig[0];
                        // exp = all-ones is also caught here so exp+1 can never wrap to zero.
                        if (bus.exp >= EXP_ALL1 - EXP_W'(1)) begin
                            w_overflow_nxt = 1'b1;
                            w_sig_nxt      = '0;
                            w_exp_nxt      = EXP_ALL1;
                        end else begin
                            w_sig_nxt = {1'b1, bus.sig[SIG_W-1:1]};
                            w_exp_nxt = bus.exp + EXP_W'(1);
                        end
                    end else if (bus.sig == '0) begin
                        w_exp_nxt  = '0;
                        w_zero_nxt = 1'b1;
                    end else if (bus.exp == '0) begin
                        w_denorm_nxt = 1'b1;
                    end else if (bus.sig[SIG_W-1]) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.exp == EXP_W'(1)) begin
                        w_exp_nxt    = '0;
                        w_denorm_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                // exp_r >= 2 and MSB = 0 here, so every step moves at least one position.
                w_sig_nxt    = w_sig_sh;
                w_exp_nxt    = w_exp_sh;
                w_lshift_nxt = r_lshift + w_k;
                if (w_sig_sh[SIG_W-1]) begin
                    w_state_nxt = S_DONE;
                end else if (w_exp_sh == EXP_W'(1)) begin
                    // Ran out of exponent before reaching a leading one: becomes denormal.
                    w_exp_nxt    = '0;
                    w_denorm_nxt = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sig_norm  = r_sig;
    assign bus.exp_norm  = r_exp;
    assign bus.lshift    = r_lshift;
    assign bus.sticky    = r_sticky;
    assign bus.zero      = r_zero;
    assign bus.denorm    = r_denorm;
    assign bus.overflow  = r_overflow;

endmodule
